// File: rtl/hack_kbd_pkg.sv
// Shared types, Hack special-key codes and the PS/2 set-2 to Hack key map.
package hack_kbd_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    localparam logic [7:0] HK_SPACE  = 8'd32;
    localparam logic [7:0] HK_ENTER  = 8'd128;
    localparam logic [7:0] HK_BKSP   = 8'd129;
    localparam logic [7:0] HK_LEFT   = 8'd130;
    localparam logic [7:0] HK_UP     = 8'd131;
    localparam logic [7:0] HK_RIGHT  = 8'd132;
    localparam logic [7:0] HK_DOWN   = 8'd133;
    localparam logic [7:0] HK_HOME   = 8'd134;
    localparam logic [7:0] HK_END    = 8'd135;
    localparam logic [7:0] HK_PGUP   = 8'd136;
    localparam logic [7:0] HK_PGDN   = 8'd137;
    localparam logic [7:0] HK_INSERT = 8'd138;
    localparam logic [7:0] HK_DELETE = 8'd139;
    localparam logic [7:0] HK_ESC    = 8'd140;
    localparam logic [7:0] HK_F1     = 8'd141;

    // Returns 0 for unmapped keys.
    function automatic logic [7:0] ps2_to_hack(input logic ext, input logic shift,
                                               input logic [7:0] code);
        logic [7:0] r;
        r = 8'd0;
        if (ext) begin
            case (code)
                8'h6B: r = HK_LEFT;
                8'h75: r = HK_UP;
                8'h74: r = HK_RIGHT;
                8'h72: r = HK_DOWN;
                8'h6C: r = HK_HOME;
                8'h69: r = HK_END;
                8'h7D: r = HK_PGUP;
                8'h7A: r = HK_PGDN;
                8'h70: r = HK_INSERT;
                8'h71: r = HK_DELETE;
                8'h5A: r = HK_ENTER;
                default: r = 8'd0;
            endcase
        end else begin
            case (code)
                8'h1C: r = 8'd65;  8'h32: r = 8'd66;  8'h21: r = 8'd67;  8'h23: r = 8'd68;
                8'h24: r = 8'd69;  8'h2B: r = 8'd70;  8'h34: r = 8'd71;  8'h33: r = 8'd72;
                8'h43: r = 8'd73;  8'h3B: r = 8'd74;  8'h42: r = 8'd75;  8'h4B: r = 8'd76;
                8'h3A: r = 8'd77;  8'h31: r = 8'd78;  8'h44: r = 8'd79;  8'h4D: r = 8'd80;
                8'h15: r = 8'd81;  8'h2D: r = 8'd82;  8'h1B: r = 8'd83;  8'h2C: r = 8'd84;
                8'h3C: r = 8'd85;  8'h2A: r = 8'd86;  8'h1D: r = 8'd87;  8'h22: r = 8'd88;
                8'h35: r = 8'd89;  8'h1A: r = 8'd90;
                8'h45: r = shift ? 8'd41  : 8'd48;
                8'h16: r = shift ? 8'd33  : 8'd49;
                8'h1E: r = shift ? 8'd64  : 8'd50;
                8'h26: r = shift ? 8'd35  : 8'd51;
                8'h25: r = shift ? 8'd36  : 8'd52;
                8'h2E: r = shift ? 8'd37  : 8'd53;
                8'h36: r = shift ? 8'd94  : 8'd54;
                8'h3D: r = shift ? 8'd38  : 8'd55;
                8'h3E: r = shift ? 8'd42  : 8'd56;
                8'h46: r = shift ? 8'd40  : 8'd57;
                8'h0E: r = shift ? 8'd126 : 8'd96;
                8'h4E: r = shift ? 8'd95  : 8'd45;
                8'h55: r = shift ? 8'd43  : 8'd61;
                8'h54: r = shift ? 8'd123 : 8'd91;
                8'h5B: r = shift ? 8'd125 : 8'd93;
                8'h5D: r = shift ? 8'd124 : 8'd92;
                8'h4C: r = shift ? 8'd58  : 8'd59;
                8'h52: r = shift ? 8'd34  : 8'd39;
                8'h41: r = shift ? 8'd60  : 8'd44;
                8'h49: r = shift ? 8'd62  : 8'd46;
                8'h4A: r = shift ? 8'd63  : 8'd47;
                8'h29: r = HK_SPACE;
                8'h5A: r = HK_ENTER;
                8'h66: r = HK_BKSP;
                8'h76: r = HK_ESC;
                8'h05: r = HK_F1;
                8'h06: r = HK_F1 + 8'd1;
                8'h04: r = HK_F1 + 8'd2;
                8'h0C: r = HK_F1 + 8'd3;
                8'h03: r = HK_F1 + 8'd4;
                8'h0B: r = HK_F1 + 8'd5;
                8'h83: r = HK_F1 + 8'd6;
                8'h0A: r = HK_F1 + 8'd7;
                8'h01: r = HK_F1 + 8'd8;
                8'h09: r = HK_F1 + 8'd9;
                8'h78: r = HK_F1 + 8'd10;
                8'h07: r = HK_F1 + 8'd11;
                default: r = 8'd0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/hack_keyboard_if.sv
// Keyboard port: raw PS/2 lines in, key code and receiver status out.
interface hack_keyboard_if #(parameter int unsigned WIDTH = 16);
    logic             ps2_clk;
    logic             ps2_data;
    logic [WIDTH-1:0] key_code;
    logic             scan_valid;
    logic [7:0]       scan_code;
    logic             frame_error;

    modport slave  (input ps2_clk, ps2_data,
                    output key_code, scan_valid, scan_code, frame_error);
    modport master (output ps2_clk, ps2_data,
                    input key_code, scan_valid, scan_code, frame_error);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizer, clock glitch filter, bit FSM and frame timeout.
module ps2_rx
    import hack_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 27175
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_error
);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    rx_state_t     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          scan_valid_q, scan_valid_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          frame_error_q, frame_error_d;
    logic          strobe_c, data_s;

    assign data_s = data_sync_q[1];

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        // Filtered level follows only after FILTER_LEN consecutive differing samples.
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
            else filt_cnt_d = filt_cnt_q + FW'(1);
        end
        strobe_c = filt_q & ~filt_d;

        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        scan_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        scan_code_d   = scan_code_q;
        tcnt_d        = '0;
        if (strobe_c) begin
            case (state_q)
                RX_IDLE: if (!data_s) begin
                    state_d   = RX_DATA;
                    bit_cnt_d = 3'd0;
                end
                RX_DATA: begin
                    shreg_d   = {data_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    if (^{data_s, shreg_q}) state_d = RX_STOP;
                    else begin
                        frame_error_d = 1'b1;
                        state_d       = RX_IDLE;
                    end
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (data_s) begin
                        scan_valid_d = 1'b1;
                        scan_code_d  = shreg_q;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (state_q != RX_IDLE) begin
            // A strobe in the same cycle takes precedence over the timeout.
            if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                frame_error_d = 1'b1;
                state_d       = RX_IDLE;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_sync_q    <= 2'b11;
            data_sync_q   <= 2'b11;
            filt_q        <= 1'b1;
            filt_cnt_q    <= '0;
            tcnt_q        <= '0;
            state_q       <= RX_IDLE;
            bit_cnt_q     <= 3'd0;
            shreg_q       <= 8'd0;
            scan_valid_q  <= 1'b0;
            scan_code_q   <= 8'd0;
            frame_error_q <= 1'b0;
        end else begin
            clk_sync_q    <= {clk_sync_q[0], ps2_clk};
            data_sync_q   <= {data_sync_q[0], ps2_data};
            filt_q        <= filt_d;
            filt_cnt_q    <= filt_cnt_d;
            tcnt_q        <= tcnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            scan_valid_q  <= scan_valid_d;
            scan_code_q   <= scan_code_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign scan_valid  = scan_valid_q;
    assign scan_code   = scan_code_q;
    assign frame_error = frame_error_q;

endmodule

// File: rtl/hack_keyboard.sv
// Hack keyboard slot: PS/2 receiver plus make/break decoder holding the current key code.
module hack_keyboard
    import hack_kbd_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 27175
) (
    input  logic            clk,
    input  logic            reset,
    hack_keyboard_if.slave  kbd
);
    logic             rx_valid, rx_error;
    logic [7:0]       rx_code;
    logic             ext_q, ext_d, brk_q, brk_d, shift_q, shift_d;
    logic [WIDTH-1:0] key_code_q, key_code_d;
    logic [7:0]       mapped_c;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (kbd.ps2_clk),
        .ps2_data    (kbd.ps2_data),
        .scan_valid  (rx_valid),
        .scan_code   (rx_code),
        .frame_error (rx_error)
    );

    always_comb begin
        ext_d      = ext_q;
        brk_d      = brk_q;
        shift_d    = shift_q;
        key_code_d = key_code_q;
        mapped_c   = ps2_to_hack(ext_q, shift_q, rx_code);
        if (rx_valid) begin
            if (rx_code == 8'hE0) ext_d = 1'b1;
            else if (rx_code == 8'hF0) brk_d = 1'b1;
            else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!ext_q && (rx_code == 8'h12 || rx_code == 8'h59)) begin
                    shift_d = !brk_q;
                end else if (mapped_c != 8'd0) begin
                    // Releasing a key other than the displayed one leaves it in place.
                    if (!brk_q) key_code_d = WIDTH'(mapped_c);
                    else if (key_code_q == WIDTH'(mapped_c)) key_code_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            shift_q    <= 1'b0;
            key_code_q <= '0;
        end else begin
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            shift_q    <= shift_d;
            key_code_q <= key_code_d;
        end
    end

    assign kbd.key_code    = key_code_q;
    assign kbd.scan_valid  = rx_valid;
    assign kbd.scan_code   = rx_code;
    assign kbd.frame_error = rx_error;

endmodule
